// File: rtl/kempston_mouse_ctrl.sv
// PS/2 mouse packet framer and Kempston position accumulator.
// Ports: clk_sys/reset_n; ps2_byte/ps2_byte_stb in; mouse_state, mouse_new,
// pkt_err, wheel out. Optional 4-byte wheel packets via KMOUSE_WHEEL_EN.
module kempston_mouse_ctrl #(
  parameter int         TIMEOUT_CYC = 96000,
  parameter int         TO_W        = 17,
  parameter logic [7:0] X_INIT      = 8'd128
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  ps2_byte,
  input  logic        ps2_byte_stb,
  output logic [16:0] mouse_state,
  output logic        mouse_new,
  output logic        pkt_err,
  output logic [3:0]  wheel
);

  localparam logic [2:0] S_B0    = 3'd0;
  localparam logic [2:0] S_B1    = 3'd1;
  localparam logic [2:0] S_B2    = 3'd2;
  localparam logic [2:0] S_B3    = 3'd3;
  localparam logic [2:0] S_APPLY = 3'd4;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]      state_q, state_d;
  logic [TO_W-1:0] timer_q, timer_d;
  // flags byte bits kept: {yovf, xovf, ysign, xsign, btn}
  logic [4:0]      flg_q, flg_d;
  logic [7:0]      dx_q, dx_d;
  logic [7:0]      dy_q, dy_d;
  logic [7:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic            btn_q, btn_d;
  logic            new_q, new_d;
  logic            err_q, err_d;
  logic [7:0]      dx_add, dy_add;
  logic            commit, expired;

`ifdef KMOUSE_WHEEL_EN
  logic [3:0] b3_q, b3_d;
  logic [3:0] wh_q, wh_d;
  localparam logic [2:0] S_AFTER_DY = S_B3;
`else
  localparam logic [2:0] S_AFTER_DY = S_APPLY;
`endif

  assign commit  = (state_q == S_APPLY);
  assign expired = (timer_q == TO_LAST);
  // Overflowed axes contribute nothing; the sign bit only matters
  // beyond bit 7, which the 8-bit wrap discards.
  assign dx_add  = flg_q[3] ? 8'h00 : dx_q;
  assign dy_add  = flg_q[4] ? 8'h00 : dy_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flg_d   = flg_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    new_d   = 1'b0;
    err_d   = 1'b0;
`ifdef KMOUSE_WHEEL_EN
    b3_d    = b3_q;
    wh_d    = wh_q;
`endif
    if (commit) begin
      x_d   = x_q + dx_add;
      y_d   = y_q + dy_add;
      btn_d = flg_q[0];
      new_d = 1'b1;
`ifdef KMOUSE_WHEEL_EN
      wh_d  = wh_q + b3_q;
`endif
    end
    case (state_q)
      S_B0, S_APPLY: begin
        timer_d = '0;
        state_d = S_B0;
        if (ps2_byte_stb) begin
          if (ps2_byte[3]) begin
            flg_d   = {ps2_byte[7:4], ps2_byte[0]};
            state_d = S_B1;
          end else begin
            // A bad header in APPLY is dropped silently so
            // pkt_err never coincides with mouse_new.
            err_d = ~commit;
          end
        end
      end
      S_B1, S_B2, S_B3: begin
        if (ps2_byte_stb) begin
          timer_d = '0;
          unique case (1'b1)
            (state_q == S_B1): begin
              dx_d    = ps2_byte;
              state_d = S_B2;
            end
            (state_q == S_B2): begin
              dy_d    = ps2_byte;
              state_d = S_AFTER_DY;
            end
            default: begin
`ifdef KMOUSE_WHEEL_EN
              b3_d    = ps2_byte[3:0];
`endif
              state_d = S_APPLY;
            end
          endcase
        end else if (expired) begin
          timer_d = '0;
          state_d = S_B0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_B0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_B0;
      timer_q <= '0;
      flg_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      x_q     <= X_INIT;
      y_q     <= '0;
      btn_q   <= 1'b0;
      new_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      flg_q   <= flg_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      new_q   <= new_d;
      err_q   <= err_d;
    end
  end

`ifdef KMOUSE_WHEEL_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      b3_q <= '0;
      wh_q <= '0;
    end else begin
      b3_q <= b3_d;
      wh_q <= wh_d;
    end
  end
  assign wheel = wh_q;
`else
  assign wheel = 4'h0;
`endif

  assign mouse_state = {btn_q, y_q, x_q};
  assign mouse_new   = new_q;
  assign pkt_err     = err_q;

endmodule

// File: tb/tb_kempston_mouse_ctrl.sv
// Bench for kempston_mouse_ctrl: packet-level model plus directed vectors.
// Targets the default build (3-byte packets, wheel tied to zero).
module tb_kempston_mouse_ctrl;

  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [7:0]  bt = 8'h00;
  logic [16:0] ms;
  logic        mnew;
  logic        perr;
  logic [3:0]  wh;

  int total = 0;
  int bad   = 0;

  kempston_mouse_ctrl #(
    .TIMEOUT_CYC(T),
    .TO_W(6),
    .X_INIT(8'd128)
  ) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .ps2_byte(bt),
    .ps2_byte_stb(stb),
    .mouse_state(ms),
    .mouse_new(mnew),
    .pkt_err(perr),
    .wheel(wh)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: collected packet bytes, idle-cycle count, pending commit
  int         mx = 128;
  int         my = 0;
  bit         mbtn = 0;
  bit         e_new = 0;
  bit         e_err = 0;
  logic [7:0] pkt[$];
  int         idle = 0;
  bit         pend = 0;

  function automatic int sdelta(logic [7:0] d, bit sgn, bit ovf);
    if (ovf) return 0;
    return sgn ? int'(d) - 256 : int'(d);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx = 128; my = 0; mbtn = 0;
      e_new = 0; e_err = 0;
      pkt.delete(); idle = 0; pend = 0;
    end else begin
      e_new = 0;
      e_err = 0;
      if (pend) begin
        mx = (mx + sdelta(pkt[1], pkt[0][4], pkt[0][6]) + 256) % 256;
        my = (my + sdelta(pkt[2], pkt[0][5], pkt[0][7]) + 256) % 256;
        mbtn = pkt[0][0];
        e_new = 1;
        pend = 0;
        pkt.delete();
      end
      if (stb) begin
        idle = 0;
        if (pkt.size() == 0) begin
          if (bt[3]) pkt.push_back(bt);
          else if (!e_new) e_err = 1;
        end else begin
          pkt.push_back(bt);
          if (pkt.size() == 3) pend = 1;
        end
      end else if (pkt.size() > 0) begin
        idle++;
        if (idle == T) begin
          pkt.delete();
          idle = 0;
          e_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("state", 32'(ms), 32'({mbtn, my[7:0], mx[7:0]}));
      chk("new", 32'(mnew), 32'(e_new));
      chk("err", 32'(perr), 32'(e_err));
      chk("wheel", 32'(wh), 32'h0);
    end
  end

  task automatic send(logic [7:0] b);
    stb = 1'b1;
    bt  = b;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic idle_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(ms), 32'h00080);
    chk("rst_new", 32'(mnew), 32'h0);
    chk("rst_err", 32'(perr), 32'h0);

    send(8'h08); send(8'h05); send(8'h03);
    chk("lat_pre", 32'(mnew), 32'h0);
    idle_n(1);
    chk("lat_new", 32'(mnew), 32'h1);
    chk("pkt1", 32'(ms), 32'h00385);
    idle_n(1);
    chk("lat_post", 32'(mnew), 32'h0);

    do_reset();
    send(8'h08); send(8'h80); send(8'h00); idle_n(2);
    chk("to_zero", 32'(ms), 32'h00000);
    send(8'h39); send(8'h02); send(8'hFE); idle_n(2);
    chk("neg_btn", 32'(ms), 32'h1FE02);
    send(8'h18); send(8'hFF); send(8'h00); idle_n(2);
    chk("wrap", 32'(ms), 32'h0FE01);

    send(8'h00);
    chk("bad_hdr", 32'(perr), 32'h1);
    send(8'h08); send(8'h01); send(8'h01); idle_n(2);
    chk("resync", 32'(ms), 32'h0FF02);

    send(8'h08); send(8'h10); idle_n(T);
    chk("timeout", 32'(perr), 32'h1);
    chk("to_nocommit", 32'(ms), 32'h0FF02);
    send(8'h08); send(8'h01); send(8'h01); idle_n(2);
    chk("after_to", 32'(ms), 32'h00003);

    send(8'h48); send(8'h7F); send(8'h01); idle_n(2);
    chk("xovf", 32'(ms), 32'h00103);

    send(8'h08); send(8'h01); send(8'h01);
    send(8'h08); send(8'h01); send(8'h01); idle_n(2);
    chk("b2b", 32'(ms), 32'h00305);

    send(8'h08); idle_n(T - 1);
    send(8'h02); idle_n(T - 1);
    send(8'h01); idle_n(2);
    chk("edge_win", 32'(ms), 32'h00407);

    send(8'h08); send(8'h05);
    do_reset();
    chk("mid_rst", 32'(ms), 32'h00080);
    send(8'h08); send(8'h01); send(8'h01); idle_n(2);
    chk("post_rst", 32'(ms), 32'h00181);

    idle_n(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
